// File: rtl/panda_pkg.sv
// Shared types for the Panda core memory stage: access widths, stage states
// and alignment helpers.
package panda_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } lsu_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  // log2 of the access size in bytes, capped at the bus width
  function automatic int size_log2(input lsu_width_e w, input int ow);
    int s;
    s = int'(w);
    if (s > ow) s = ow;
    return s;
  endfunction

  function automatic logic is_misaligned(input lsu_width_e w, input int off, input int ow);
    int s;
    s = size_log2(w, ow);
    return (off & ((1 << s) - 1)) != 0;
  endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Combinational lane steering for the memory stage: byte enables, store data
// replication and load extraction with sign/zero extension.
module panda_lsu_align
  import panda_pkg::*;
#(
  parameter  int DW = 32,
  localparam int BW = DW / 8,
  localparam int OW = $clog2(BW)
) (
  input  lsu_width_e        width,
  input  logic [OW-1:0]     off,
  input  logic              is_unsigned,
  input  logic [DW-1:0]     wdata_in,
  input  logic [DW-1:0]     rdata,
  output logic [BW-1:0]     be,
  output logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata_ext
);

  int            sz;
  int            nbytes;
  int            nbits;
  logic [OW-1:0] aoff;
  logic [DW-1:0] shifted;

  always_comb begin
    sz      = size_log2(width, OW);
    nbytes  = 1 << sz;
    nbits   = 8 * nbytes;
    // offset truncated down to natural alignment of the access
    aoff    = off;
    for (int b = 0; b < OW; b++) begin
      if (b < sz) aoff[b] = 1'b0;
    end
    be      = '0;
    wdata   = '0;
    for (int i = 0; i < BW; i++) begin
      be[i]          = (i >= int'(aoff)) && (i < int'(aoff) + nbytes);
      wdata[8*i +: 8] = wdata_in[8*(i % nbytes) +: 8];
    end
    shifted   = rdata >> {aoff, 3'b000};
    rdata_ext = '0;
    for (int i = 0; i < DW; i++) begin
      rdata_ext[i] = (i < nbits) ? shifted[i] : (~is_unsigned & shifted[nbits-1]);
    end
  end

endmodule

// File: rtl/panda_mem_stage_hs.sv
// Panda memory stage with req/gnt/rvalid data bus handshake.
// Build option: PANDA_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module panda_mem_stage_hs
  import panda_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int AW = 32,
  localparam int BW = DW / 8,
  localparam int OW = $clog2(BW)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ex_valid_i,
  output logic          ex_ready_o,
  input  logic          lsu_req_i,
  input  logic          lsu_store_i,
  input  logic          lsu_load_unsigned_i,
  input  logic [1:0]    lsu_width_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] store_data_i,
  input  logic [4:0]    rs2_addr_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          rd_we_i,
  input  logic [DW-1:0] result_i,
  output logic          wb_valid_o,
  output logic [4:0]    wb_rd_addr_o,
  output logic          wb_rd_we_o,
  output logic [DW-1:0] wb_data_o,
  output logic          misalign_o,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic [AW-1:0] data_addr_o,
  output logic          data_we_o,
  output logic [BW-1:0] data_be_o,
  output logic [DW-1:0] data_wdata_o,
  input  logic [DW-1:0] data_rdata_i
);

  mem_state_e    state_q, state_d;
  lsu_width_e    width_q, al_width;
  logic [OW-1:0] off_q, al_off;
  logic          uns_q, al_uns;
  logic [4:0]    rd_q;
  logic          rd_we_q;
  logic          misalign_q;
  logic          accept, fwd, misal;
  logic [DW-1:0] st_data;
  logic [BW-1:0] al_be;
  logic [DW-1:0] al_wdata, al_rdata;

  assign ex_ready_o = (state_q == IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  assign fwd        = lsu_store_i & wb_rd_we_o & (wb_rd_addr_o != 5'd0) &
                      (rs2_addr_i == wb_rd_addr_o);
  assign st_data    = fwd ? wb_data_o : store_data_i;

  // incoming fields steer the lanes at acceptance, latched ones during the access
  assign al_width = (state_q == IDLE) ? lsu_width_e'(lsu_width_i) : width_q;
  assign al_off   = (state_q == IDLE) ? addr_i[OW-1:0] : off_q;
  assign al_uns   = (state_q == IDLE) ? lsu_load_unsigned_i : uns_q;

`ifdef PANDA_MISALIGN_TRAP_EN
  assign misal = lsu_req_i & is_misaligned(lsu_width_e'(lsu_width_i), int'(addr_i[OW-1:0]), OW);
`else
  assign misal = 1'b0;
`endif
  assign misalign_o = misalign_q;

  panda_lsu_align #(.DW(DW)) u_align (
    .width       (al_width),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata_in    (st_data),
    .rdata       (data_rdata_i),
    .be          (al_be),
    .wdata       (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    data_req_o = 1'b0;
    case (state_q)
      IDLE: if (accept && lsu_req_i && !misal) state_d = REQ;
      REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT;
      end
      WAIT: if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= '0;
      wb_rd_we_o   <= 1'b0;
      wb_data_o    <= '0;
      misalign_q   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      width_q      <= BYTE;
      off_q        <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (!lsu_req_i) begin
            wb_valid_o   <= 1'b1;
            wb_data_o    <= result_i;
            wb_rd_addr_o <= rd_addr_i;
            wb_rd_we_o   <= rd_we_i;
          end else if (misal) begin
            wb_valid_o   <= 1'b1;
            misalign_q   <= 1'b1;
            wb_data_o    <= DW'(addr_i);
            wb_rd_addr_o <= rd_addr_i;
            wb_rd_we_o   <= 1'b0;
          end else begin
            data_addr_o  <= {addr_i[AW-1:OW], {OW{1'b0}}};
            data_we_o    <= lsu_store_i;
            data_be_o    <= al_be;
            data_wdata_o <= al_wdata;
            width_q      <= lsu_width_e'(lsu_width_i);
            off_q        <= addr_i[OW-1:0];
            uns_q        <= lsu_load_unsigned_i;
            rd_q         <= rd_addr_i;
            rd_we_q      <= rd_we_i;
          end
        end
        WAIT: if (data_rvalid_i) begin
          wb_valid_o   <= 1'b1;
          wb_data_o    <= data_we_o ? '0 : al_rdata;
          wb_rd_addr_o <= rd_q;
          wb_rd_we_o   <= rd_we_q & ~data_we_o;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/panda_mem_stage_hs.md
Name: panda_mem_stage_hs

Overview:
- Pipelined memory stage for the Panda core. It sits between the EX/MEM and MEM/WB pipeline boundaries.
- Replaces the single-cycle, always-ready data port with a request/grant/rvalid data bus handshake. This lets the stage stall EX on slow memory.
- Parametrised data width (32 or 64 bit). Byte enables replace the write-enable vector.
- Store-data forwarding from the WB register is qualified by rd_we and rd != x0.

Parameters:
- DW, 32: data bus width; legal values 32 and 64.
- AW, 32: address width.
- BW, DW/8: byte-enable width; derived, not overridable.
- OW, $clog2(BW): number of byte-offset address bits; derived.

Ports:
- clk_i  in  1  clock; all flops on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ex_valid_i  in  1  EX presents an instruction.
- ex_ready_o  out  1  stage accepts the instruction this cycle.
- lsu_req_i  in  1  instruction is a load or a store.
- lsu_store_i  in  1  1 = store, 0 = load.
- lsu_load_unsigned_i  in  1  zero-extend the load result.
- lsu_width_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double (DW = 64 only).
- addr_i  in  AW  effective address (ALU result).
- store_data_i  in  DW  rs2 value.
- rs2_addr_i  in  5  rs2 index, used for forwarding.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  destination write enable.
- result_i  in  DW  non-load result, already selected in EX.
- wb_valid_o  out  1  one-cycle pulse: WB fields are valid.
- wb_rd_addr_o  out  5  registered destination register.
- wb_rd_we_o  out  1  registered write enable.
- wb_data_o  out  DW  load data or result_i.
- misalign_o  out  1  misaligned access flag (see Optional Feature).
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_rvalid_i  in  1  response valid.
- data_addr_o  out  AW  bus address, aligned down to BW.
- data_we_o  out  1  bus write.
- data_be_o  out  BW  byte enables.
- data_wdata_o  out  DW  write data, lane-replicated.
- data_rdata_i  in  DW  read data.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE.
  - All wb_* outputs, misalign_o, data_req_o, data_we_o, data_be_o, data_addr_o and data_wdata_o = 0.
- States: IDLE, REQ, WAIT.
- ex_ready_o = 1 only in IDLE.
- IDLE, instruction accepted (ex_valid_i & ex_ready_o):
  - Non-memory op: next cycle wb_valid_o = 1 and wb_data_o = result_i; stay in IDLE.
  - Memory op: latch the bus fields (address, we, be, wdata, rd, width, unsigned) and go to REQ.
- REQ: data_req_o = 1. All data_* outputs are held stable until data_gnt_i. On grant, go to WAIT.
- WAIT:
  - data_req_o = 0.
  - On data_rvalid_i: register the load-extracted data (or 0 for a store) into wb_data_o.
  - Next cycle wb_valid_o = 1; state returns to IDLE.
  - A store pulses wb_valid_o with wb_rd_we_o = 0.
- Latency:
  - Non-memory: 1 cycle.
  - Memory, with gnt in the first REQ cycle and rvalid on the next cycle: wb_valid_o 3 cycles after acceptance.
- data_rvalid_i outside WAIT is ignored. The bench asserts it never occurs.
- data_gnt_i outside REQ is ignored.
- Byte enables:
  - byte: be = 1 << off.
  - half: be = 3 << (off & ~1).
  - word: be = 0xF << (off & ~3).
  - double: all ones.
- Write data: the low-order item is replicated across all lanes.
- Load: rdata is shifted right by off*8, masked to the access width, then sign- or zero-extended to DW.
- Forwarding: store_data = wb_data_o when, at acceptance, all of the following hold:
  - lsu_store_i;
  - wb_rd_we_o;
  - wb_rd_addr_o != 0;
  - rs2_addr_i == wb_rd_addr_o.
  Otherwise store_data = store_data_i.
- Reset mid-transaction: the stage abandons the access and returns to IDLE. A later rvalid is ignored and wb_valid_o is not pulsed.

Optional Feature:
- PANDA_MISALIGN_TRAP_EN defined:
  - A memory op whose address is not naturally aligned issues no bus request.
  - Next cycle: wb_valid_o = 1, misalign_o = 1, wb_rd_we_o = 0, wb_data_o = zero-extended addr_i.
  - misalign_o is 0 on all other pulses.
- Undefined: misalign_o is tied 0. The offset is truncated to natural alignment (byte access unaffected) and the access proceeds.

Decomposition:
- panda_pkg gains:
  - lsu_width_e (BYTE, HALF, WORD, DOUBLE);
  - mem_state_e (IDLE, REQ, WAIT).
- Sub-module panda_lsu_align, combinational, parametrised on DW: width + offset -> be, wdata replication, load extraction/extension.

Test Plan:
- Non-memory op with result_i = 0x1234, rd = 5 -> next cycle wb_valid_o = 1, wb_data_o = 0x1234, wb_rd_we_o = 1, ex_ready_o stays 1.
- Store byte, addr 0x103, data 0xAB, gnt delayed 3 cycles -> data_req_o high for 4 cycles; be = 0x8, wdata = 0xABABABAB, addr = 0x100 held stable; ex_ready_o = 0 until return to IDLE.
- Signed half load, addr 0x202, rdata = 0x80010000 -> wb_data_o = 0xFFFF8001. Same access unsigned -> 0x00008001.
- Load x7 followed by store with rs2 = x7 -> store wdata equals the load result. Repeat with rd = x0 -> store_data_i is used.
- Reset asserted in WAIT, then rvalid arrives -> no wb_valid_o pulse; state IDLE; data_req_o = 0.
- With PANDA_MISALIGN_TRAP_EN, word load at 0x101 -> data_req_o never asserted; wb_valid_o = 1, misalign_o = 1, wb_data_o = 0x101. With DW = 64, double load at 0x8 -> be = 0xFF.
